// File: rtl/multi_dataflow_sobel_mdc_engine_ctrl.sv
// Engine-side control responder for the Sobel MDC HWPE: gates the input streams into
// the kernel, buffers the kernel output in a one-entry slice and counts output beats.
module multi_dataflow_sobel_mdc_engine_ctrl #(
   parameter int unsigned CNT_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  test_mode_i,
   input  logic                  clear_i,
   input  logic                  start_i,
   input  logic                  clear_ctrl_i,
   input  logic                  enable_i,
   input  logic [CNT_WIDTH-1:0]  cnt_limit_i,
   output logic                  ready_o,
   output logic                  done_o,
   output logic [CNT_WIDTH-1:0]  cnt_o,
   input  logic                  in_pel_valid_i,
   input  logic [DATA_WIDTH-1:0] in_pel_data_i,
   output logic                  in_pel_ready_o,
   input  logic                  in_size_valid_i,
   input  logic [DATA_WIDTH-1:0] in_size_data_i,
   output logic                  in_size_ready_o,
   output logic                  kern_in_pel_valid_o,
   output logic [DATA_WIDTH-1:0] kern_in_pel_data_o,
   input  logic                  kern_in_pel_ready_i,
   output logic                  kern_in_size_valid_o,
   output logic [DATA_WIDTH-1:0] kern_in_size_data_o,
   input  logic                  kern_in_size_ready_i,
   input  logic                  kern_out_pel_valid_i,
   input  logic [DATA_WIDTH-1:0] kern_out_pel_data_i,
   output logic                  kern_out_pel_ready_o,
   output logic                  out_pel_valid_o,
   output logic [DATA_WIDTH-1:0] out_pel_data_o,
   input  logic                  out_pel_ready_i
);

   // state  | meaning
   // IDLE   | waiting for start, ready_o high, gates closed
   // RUN    | job active, gates open while enable_i is high
   // DONE   | one-cycle completion pulse, slice flushed
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]            r_state;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [CNT_WIDTH-1:0]  r_limit;
   logic                  r_full;
   logic [DATA_WIDTH-1:0] r_data;

   logic                  w_run_en;
   logic                  w_cap;
   logic                  w_dep;
   logic [CNT_WIDTH-1:0]  w_cnt_nxt;
   logic                  w_unused;

   assign w_unused  = test_mode_i;
   assign w_run_en  = (r_state == S_RUN) && enable_i;
   assign w_cnt_nxt = r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   assign ready_o = (r_state == S_IDLE);
   assign done_o  = (r_state == S_DONE);
   assign cnt_o   = r_cnt;

   assign kern_in_pel_valid_o  = w_run_en & in_pel_valid_i;
   assign kern_in_pel_data_o   = in_pel_data_i;
   assign in_pel_ready_o       = w_run_en & kern_in_pel_ready_i;
   assign kern_in_size_valid_o = w_run_en & in_size_valid_i;
   assign kern_in_size_data_o  = in_size_data_i;
   assign in_size_ready_o      = w_run_en & kern_in_size_ready_i;

   // Ready while empty or draining in the same cycle, so the slice sustains one beat per cycle.
   assign kern_out_pel_ready_o = w_run_en & (~r_full | out_pel_ready_i);
   assign out_pel_valid_o      = w_run_en & r_full;
   assign out_pel_data_o       = r_data;

   assign w_cap = kern_out_pel_valid_i & kern_out_pel_ready_o;
   assign w_dep = out_pel_valid_o & out_pel_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_limit <= '0;
         r_full  <= 1'b0;
         r_data  <= '0;
      end else if (clear_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_limit <= '0;
         r_full  <= 1'b0;
         r_data  <= '0;
      end else if (clear_ctrl_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_full  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i && enable_i) begin
                  r_cnt   <= '0;
                  r_full  <= 1'b0;
                  r_limit <= cnt_limit_i;
                  r_state <= (cnt_limit_i == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (w_cap) begin
                  r_full <= 1'b1;
                  r_data <= kern_out_pel_data_i;
               end else if (w_dep) begin
                  r_full <= 1'b0;
               end
               // A beat captured alongside the final departure is intentionally dropped.
               if (w_dep) begin
                  r_cnt <= w_cnt_nxt;
                  if (w_cnt_nxt == r_limit) begin
                     r_state <= S_DONE;
                     r_full  <= 1'b0;
                  end
               end
            end
            S_DONE: begin
               r_full  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/multi_dataflow_sobel_mdc_engine_ctrl.md
# multi_dataflow_sobel_mdc_engine_ctrl

Engine-side control responder for the Sobel MDC HWPE. It consumes the `ctrl_engine` commands (start/clear/enable/cnt_limit) issued by the HWPE control FSM and returns the `flags_engine` status (ready, out-pel count). It gates the in_pel/in_size streams into the MDC kernel and buffers the kernel's out_pel stream in a one-entry register slice. It counts accepted output beats and stops the engine when the programmed limit is reached.

## Interface
- CNT_WIDTH, 32, width of cnt_limit_i / cnt_o (matches cnt_limit_out_pel)
- DATA_WIDTH, 32, stream data width for all three streams
- clk_i  in  1  clock
- rst_ni  in  1  reset: asynchronous, active-low; clock clk_i
- test_mode_i  in  1  reserved, no functional effect
- clear_i  in  1  global synchronous clear, equivalent to reset
- start_i  in  1  engine start (ctrl_engine.start)
- clear_ctrl_i  in  1  engine clear (ctrl_engine.clear)
- enable_i  in  1  engine enable (ctrl_engine.enable)
- cnt_limit_i  in  CNT_WIDTH  output beats per job (ctrl_engine.cnt_limit_out_pel)
- ready_o  out  1  engine ready for a new start (flags_engine.ready)
- done_o  out  1  one-cycle job-complete pulse
- cnt_o  out  CNT_WIDTH  accepted out_pel beats (flags_engine.cnt_out_pel)
- in_pel_valid_i / in_pel_data_i[DATA_WIDTH] / in_pel_ready_o: streamer-side source port
- in_size_valid_i / in_size_data_i[DATA_WIDTH] / in_size_ready_o: streamer-side source port
- kern_in_pel_valid_o / kern_in_pel_data_o / kern_in_pel_ready_i: kernel-side in_pel
- kern_in_size_valid_o / kern_in_size_data_o / kern_in_size_ready_i: kernel-side in_size
- kern_out_pel_valid_i / kern_out_pel_data_i / kern_out_pel_ready_o: kernel output
- out_pel_valid_o / out_pel_data_o[DATA_WIDTH] / out_pel_ready_i: streamer-side sink port

## Operation
- States: IDLE, RUN, DONE. Reset and clear_i both go to IDLE with counter = 0 and the slice empty.
- Priority on any cycle: clear_i > clear_ctrl_i > start_i.
- IDLE:
  - ready_o = 1; all gates closed.
  - start_i & enable_i & !clear_ctrl_i: counter := 0, slice flushed.
    - If cnt_limit_i == 0, go to DONE; otherwise go to RUN.
- RUN:
  - ready_o = 0; start_i is ignored.
  - With enable_i = 1, the input gates are transparent: kern_in_x_valid_o = in_x_valid_i, in_x_ready_o = kern_in_x_ready_i, and data passes through.
  - With enable_i = 0, all gates are closed. Slice contents and counter are held.
- Output slice (single entry, RUN with enable_i only):
  - kern_out_pel_ready_o = !full | out_pel_ready_i.
  - out_pel_valid_o = full.
  - A beat is captured when kern_out_pel_valid_i & kern_out_pel_ready_o. Simultaneous capture and departure is allowed, giving full throughput.
- Counter:
  - Increments by 1 on each departure (out_pel_valid_o & out_pel_ready_i).
  - The departure that makes counter == latched limit moves the state to DONE.
  - The limit is latched at start; cnt_limit_i changes during RUN are ignored.
- DONE: one cycle. done_o = 1, gates closed, slice flushed (any beat captured alongside the final departure is dropped), then IDLE.
- cnt_o = counter register. It holds its value in IDLE until a new start, clear_ctrl_i or clear_i.
- clear_ctrl_i in IDLE, RUN or DONE: next cycle IDLE, counter = 0, slice empty, no done_o.
- Gates closed means: in_x_ready_o = 0, kern_in_x_valid_o = 0, kern_out_pel_ready_o = 0, out_pel_valid_o = 0.

## Timing
- Reset values: ready_o = 1, done_o = 0, cnt_o = 0, all valid/ready outputs = 0. Data outputs: slice data = 0; pass-through data follows inputs.
- start_i at cycle t: RUN and gates open at t+1, ready_o = 0 at t+1.
- Input path latency: 0 cycles (combinational pass-through).
- Output path latency: kernel beat captured at t appears on out_pel_valid_o at t+1.
- cnt_o updates the cycle after each departure.
- Final departure at cycle t: done_o = 1 and cnt_o = limit at t+1; ready_o = 1 at t+2.
- cnt_limit_i == 0 at start t: done_o = 1 at t+1 with no stream activity.
- No combinational path from start_i, clear_ctrl_i or enable_i to done_o.
- Counter does not wrap: it saturates at the limit because the state leaves RUN.

## Test plan
- Basic job:
  - Stimulus: limit 4, start at t, kernel echoes in_pel, out_pel_ready_i = 1.
  - Required: 4 out beats in input order; cnt_o steps 1..4; done_o single pulse the cycle after the 4th departure; ready_o returns 1 one cycle later.
- Zero limit:
  - Stimulus: cnt_limit_i = 0, start at t.
  - Required: done_o = 1 at t+1; in_pel_ready_o stays 0 throughout; cnt_o = 0.
- Backpressure:
  - Stimulus: limit 8, slice full, out_pel_ready_i = 0 for 5 cycles.
  - Required: kern_out_pel_ready_o = 0 for those cycles; out_pel_data_o stable; no loss or duplication; cnt_o reaches 8.
- Enable low:
  - Stimulus: enable_i = 0 for 3 cycles at cnt_o = 2.
  - Required: all gates closed; cnt_o frozen at 2; slice data held; progress resumes when enable_i returns to 1.
- Abort:
  - Stimulus: clear_ctrl_i at cnt_o = 3 (limit 6).
  - Required: IDLE next cycle, cnt_o = 0, out_pel_valid_o = 0, no done_o pulse; a following start with limit 2 completes normally.
- Async reset:
  - Stimulus: rst_ni low mid-RUN.
  - Required: all outputs at their reset values immediately, without waiting for a clock edge; ready_o = 1 after release.
